product_accumulator: RTL and testbench
======================================

PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 Parameter COUNT, default 4, products per batch, legal range 2..16.
REQ-002 Parameter ACC_WIDTH, default 10, accumulator and Sum_Out width, legal range 8..16.
REQ-003 Clock  in  1  single clock; all state updates on rising edge.
REQ-004 Reset_n  in  1  asynchronous active-low reset.
REQ-005 Product_In  in  8  unsigned product from the 4-bit multiplier stage.
REQ-006 Product_Valid_In  in  1  Product_In valid this cycle.
REQ-007 Product_Ready_Out  out  1  block can accept a product this cycle.
REQ-008 Clear_In  in  1  synchronous batch abort.
REQ-009 Sum_Out  out  ACC_WIDTH  running or final accumulated sum.
REQ-010 Sum_Valid_Out  out  1  Sum_Out holds a completed batch.
REQ-011 Sum_Ready_In  in  1  consumer accepts the completed sum.
REQ-012 Overflow_Out  out  1  sticky; the current batch exceeded 2^ACC_WIDTH-1.
REQ-013 Count_Out  out  5  products accepted in the current batch.

Function
REQ-014 The FSM SHALL have exactly two states: ACCUM (accepting products) and HOLD (presenting the result).
REQ-015 Product_Ready_Out SHALL be 1 in ACCUM and 0 in HOLD, driven from state only.
REQ-016 Product transfer SHALL occur at a rising edge when Product_Valid_In=1 and Product_Ready_Out=1.
REQ-017 On transfer: accumulator <= accumulator + zero-extended Product_In; Count_Out increments by 1.
REQ-018 On the COUNT-th transfer the FSM SHALL enter HOLD, so Sum_Valid_Out=1 in the cycle after that transfer (latency 1).
REQ-019 In HOLD, Sum_Out, Overflow_Out and Count_Out SHALL be held stable until the result is taken.
REQ-020 Result transfer SHALL occur at a rising edge in HOLD when Sum_Ready_In=1; the FSM then returns to ACCUM with accumulator=0, Count_Out=0, Overflow_Out=0 and Sum_Valid_Out=0.
REQ-021 Product_In SHALL NOT be accepted in the cycle the result is taken; no bypass path exists.
REQ-022 In ACCUM, Sum_Out SHALL show the running partial sum; Sum_Valid_Out SHALL be 0.
REQ-023 Idle cycles (Product_Valid_In=0) in ACCUM SHALL leave all state unchanged.
REQ-024 Clear_In=1 SHALL take priority over all other inputs: next state ACCUM, accumulator=0, Count_Out=0, Overflow_Out=0, Sum_Valid_Out=0.
REQ-025 A product presented in the same cycle as Clear_In SHALL be discarded.
REQ-026 Overflow_Out SHALL set when an addition carries out of ACC_WIDTH bits and stay set until a result transfer, Clear_In or reset.

Reset
REQ-027 Reset_n=0 SHALL immediately force state ACCUM, Sum_Out=0, Sum_Valid_Out=0, Overflow_Out=0 and Count_Out=0, with Product_Ready_Out=1 once in ACCUM.
REQ-028 Reset asserted mid-batch or in HOLD SHALL discard the batch; no partial result is emitted after release.
REQ-029 After Reset_n deasserts, the first rising edge SHALL be able to accept a product.

Configuration
REQ-030 Macro PRODUCT_ACCUMULATOR_SATURATE_EN SHALL select the overflow behaviour.
REQ-031 With PRODUCT_ACCUMULATOR_SATURATE_EN undefined, the accumulator SHALL wrap modulo 2^ACC_WIDTH.
REQ-032 With PRODUCT_ACCUMULATOR_SATURATE_EN defined, the accumulator SHALL clamp at 2^ACC_WIDTH-1 and remain there for the rest of the batch; Overflow_Out behaves as in REQ-026.

Verification
REQ-033 COUNT=4, ACC_WIDTH=10; products 225, 225, 225, 225 back-to-back -> Sum_Valid_Out=1 one cycle after the 4th transfer, Sum_Out=900, Overflow_Out=0, Count_Out=4.
REQ-034 COUNT=8, ACC_WIDTH=10; eight products of 225 -> Overflow_Out=1; Sum_Out=776 with the macro undefined, or Sum_Out=1023 with PRODUCT_ACCUMULATOR_SATURATE_EN defined.
REQ-035 Complete a batch, then hold Sum_Ready_In=0 for 5 cycles with Product_Valid_In=1 -> Product_Ready_Out=0, Sum_Out stable, no product accepted; Sum_Ready_In=1 -> next cycle Sum_Valid_Out=0, Count_Out=0.
REQ-036 Accept products 10 and 20, then Clear_In=1 together with product 99 -> Count_Out=0, Sum_Out=0; then four products of 1 -> Sum_Out=4.
REQ-037 Products 10, 20, 30, 40 separated by 0-3 idle cycles -> Sum_Out=100, latency still 1 cycle after the 4th transfer.
REQ-038 Reset_n=0 asynchronously after 3 products -> all outputs zero before the next edge; after release a full batch of 4x50 -> Sum_Out=200.

Source files
------------

// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT unsigned 8-bit products into an ACC_WIDTH-bit
// accumulator. After the last product of a batch it holds the result until the
// consumer takes it.
// Build option: PRODUCT_ACCUMULATOR_SATURATE_EN makes the accumulator clamp at
// all-ones on overflow. Without it the accumulator wraps modulo 2^ACC_WIDTH.
module product_accumulator #(
  parameter int COUNT     = 4,
  parameter int ACC_WIDTH = 10
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [7:0]           Product_In,
  input  logic                 Product_Valid_In,
  output logic                 Product_Ready_Out,
  input  logic                 Clear_In,
  output logic [ACC_WIDTH-1:0] Sum_Out,
  output logic                 Sum_Valid_Out,
  input  logic                 Sum_Ready_In,
  output logic                 Overflow_Out,
  output logic [4:0]           Count_Out
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(COUNT - 1);

  state_t               state;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] acc_next;
  logic [ACC_WIDTH:0]   sum_ext;
  logic                 carry;
  logic [4:0]           cnt;
  logic                 ovf;

  // Extended-width add exposes the carry out of the accumulator.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_WIDTH - 7){1'b0}}, Product_In};
    carry   = sum_ext[ACC_WIDTH];
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    acc_next = carry ? '1 : sum_ext[ACC_WIDTH-1:0];
`else
    acc_next = sum_ext[ACC_WIDTH-1:0];
`endif
  end

  // Batch state: accept products in ACCUM, present the result in HOLD.
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else if (Clear_In) begin
      state <= ACCUM;
      acc   <= '0;
      cnt   <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (Product_Valid_In) begin
            acc <= acc_next;
            cnt <= cnt + 5'd1;
            if (carry) begin
              ovf <= 1'b1;
            end
            if (cnt == LAST_IDX) begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (Sum_Ready_In) begin
            state <= ACCUM;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  // All outputs come straight from registered state.
  always_comb begin
    Product_Ready_Out = (state == ACCUM);
    Sum_Valid_Out     = (state == HOLD);
    Sum_Out           = acc;
    Overflow_Out      = ovf;
    Count_Out         = cnt;
  end

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: drives two instances (COUNT=4 and COUNT=8, both with
// ACC_WIDTH=10) from shared inputs and compares them with a model that keeps the
// true integer batch total.
// The expected sums follow PRODUCT_ACCUMULATOR_SATURATE_EN when it is defined.
module tb_product_accumulator;

  localparam int W   = 10;
  localparam int MAX = (1 << W) - 1;

  logic         Clock;
  logic         Reset_n;
  logic [7:0]   Product_In;
  logic         Product_Valid_In;
  logic         Clear_In;
  logic         Sum_Ready_In;

  logic         ready_a, valid_a, ovf_a;
  logic [W-1:0] sum_a;
  logic [4:0]   cnt_a;
  logic         ready_b, valid_b, ovf_b;
  logic [W-1:0] sum_b;
  logic [4:0]   cnt_b;

  int checks = 0;
  int errors = 0;

  // Model state: true total, number of products taken, and whether a result is held.
  int model_total [2];
  int model_n     [2];
  bit model_hold  [2];
  int batch_len   [2];

  product_accumulator #(.COUNT(4), .ACC_WIDTH(W)) dut_a (
    .Clock(Clock), .Reset_n(Reset_n), .Product_In(Product_In),
    .Product_Valid_In(Product_Valid_In), .Product_Ready_Out(ready_a),
    .Clear_In(Clear_In), .Sum_Out(sum_a), .Sum_Valid_Out(valid_a),
    .Sum_Ready_In(Sum_Ready_In), .Overflow_Out(ovf_a), .Count_Out(cnt_a)
  );

  product_accumulator #(.COUNT(8), .ACC_WIDTH(W)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .Product_In(Product_In),
    .Product_Valid_In(Product_Valid_In), .Product_Ready_Out(ready_b),
    .Clear_In(Clear_In), .Sum_Out(sum_b), .Sum_Valid_Out(valid_b),
    .Sum_Ready_In(Sum_Ready_In), .Overflow_Out(ovf_b), .Count_Out(cnt_b)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int exp_sum(input int total);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    return (total > MAX) ? MAX : total;
`else
    return total % (MAX + 1);
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      model_total[i] = 0;
      model_n[i]     = 0;
      model_hold[i]  = 1'b0;
    end
  endtask

  // Applies the batch rules to the inputs present at this rising edge.
  task automatic model_update();
    for (int i = 0; i < 2; i++) begin
      if (!Reset_n || Clear_In) begin
        model_total[i] = 0;
        model_n[i]     = 0;
        model_hold[i]  = 1'b0;
      end else if (model_hold[i]) begin
        if (Sum_Ready_In) begin
          model_total[i] = 0;
          model_n[i]     = 0;
          model_hold[i]  = 1'b0;
        end
      end else if (Product_Valid_In) begin
        model_total[i] += int'(Product_In);
        model_n[i]++;
        if (model_n[i] == batch_len[i]) model_hold[i] = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    check("a_ready", int'(ready_a), int'(!model_hold[0]));
    check("a_valid", int'(valid_a), int'(model_hold[0]));
    check("a_sum",   int'(sum_a),   exp_sum(model_total[0]));
    check("a_ovf",   int'(ovf_a),   int'(model_total[0] > MAX));
    check("a_count", int'(cnt_a),   model_n[0]);
    check("b_ready", int'(ready_b), int'(!model_hold[1]));
    check("b_valid", int'(valid_b), int'(model_hold[1]));
    check("b_sum",   int'(sum_b),   exp_sum(model_total[1]));
    check("b_ovf",   int'(ovf_b),   int'(model_total[1] > MAX));
    check("b_count", int'(cnt_b),   model_n[1]);
  endtask

  task automatic step();
    @(posedge Clock);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input int p, input bit clr, input bit rdy);
    Product_Valid_In = v;
    Product_In       = 8'(p);
    Clear_In         = clr;
    Sum_Ready_In     = rdy;
    step();
  endtask

  initial begin
    batch_len[0] = 4;
    batch_len[1] = 8;
    Reset_n          = 1'b0;
    Product_In       = '0;
    Product_Valid_In = 1'b0;
    Clear_In         = 1'b0;
    Sum_Ready_In     = 1'b0;
    model_reset();
    #2;
    compare_all();
    #10;
    Reset_n = 1'b1;

    // Back-to-back 225s: A completes at 4 with 900, B overflows after 8.
    for (int k = 0; k < 4; k++) drive(1'b1, 225, 1'b0, 1'b0);
    check("a_valid_latency", int'(valid_a), 1);
    check("a_sum_900", int'(sum_a), 900);
    check("a_ovf_900", int'(ovf_a), 0);
    check("a_count_4", int'(cnt_a), 4);
    for (int k = 0; k < 4; k++) drive(1'b1, 225, 1'b0, 1'b0);
    check("a_held_sum", int'(sum_a), 900);
    check("a_held_ready", int'(ready_a), 0);
    check("b_ovf_8x225", int'(ovf_b), 1);
`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
    check("b_sum_8x225", int'(sum_b), 1023);
`else
    check("b_sum_8x225", int'(sum_b), 776);
`endif
    // Five more stalled cycles with a product offered.
    for (int k = 0; k < 5; k++) drive(1'b1, 77, 1'b0, 1'b0);
    drive(1'b1, 77, 1'b0, 1'b1);
    check("a_taken_valid", int'(valid_a), 0);
    check("a_taken_count", int'(cnt_a), 0);
    check("b_taken_ovf", int'(ovf_b), 0);

    // Clear with a coincident product, then a fresh batch of ones.
    drive(1'b1, 10, 1'b0, 1'b0);
    drive(1'b1, 20, 1'b0, 1'b0);
    drive(1'b1, 99, 1'b1, 1'b0);
    check("clear_count", int'(cnt_a), 0);
    check("clear_sum", int'(sum_a), 0);
    for (int k = 0; k < 4; k++) drive(1'b1, 1, 1'b0, 1'b0);
    check("a_sum_4", int'(sum_a), 4);
    drive(1'b0, 0, 1'b1, 1'b0);

    // Products separated by random idle gaps.
    for (int k = 1; k <= 4; k++) begin
      int gaps = int'($urandom_range(0, 3));
      for (int g = 0; g < gaps; g++) drive(1'b0, 0, 1'b0, 1'b0);
      drive(1'b1, 10 * k, 1'b0, 1'b0);
    end
    check("a_sum_100", int'(sum_a), 100);
    check("a_valid_100", int'(valid_a), 1);
    drive(1'b0, 0, 1'b1, 1'b0);

    // Asynchronous reset mid-batch.
    for (int k = 0; k < 3; k++) drive(1'b1, 50, 1'b0, 1'b0);
    #2;
    Reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("rst_sum_async", int'(sum_a), 0);
    check("rst_count_async", int'(cnt_a), 0);
    #2;
    Reset_n = 1'b1;
    for (int k = 0; k < 4; k++) drive(1'b1, 50, 1'b0, 1'b0);
    check("a_sum_200", int'(sum_a), 200);
    drive(1'b0, 0, 1'b0, 1'b1);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      drive(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
            bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
